// File: rtl/maze_pkg.sv
// Shared maze constants and types used by the map writers and the movement deny checkers.
package maze_pkg;

  localparam int MAZE_SIZE_Y = 20;
  localparam int MAZE_SIZE_X = 40;

  typedef logic [0:MAZE_SIZE_X-1] maze_row_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } writer_state_t;

endpackage

// File: rtl/maze_right_writer.sv
// Loads and edits the "wall on right" map consumed by the movement deny logic.
// Optional MAZE_RIGHT_BORDER_EN: column size_x-1 is pinned to 1 so the east border is always a wall.
module maze_right_writer
  import maze_pkg::*;
#(
  parameter int  size_y = MAZE_SIZE_Y,
  parameter int  size_x = MAZE_SIZE_X,
  localparam int YW     = $clog2(size_y),
  localparam int XW     = $clog2(size_x)
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          start,
  input  logic                          wr_valid,
  input  logic [0:size_x-1]             wr_row,
  output logic                          wr_ready,
  input  logic                          edit_valid,
  input  logic [YW-1:0]                 edit_y,
  input  logic [XW-1:0]                 edit_x,
  input  logic                          edit_val,
  output logic                          edit_err,
  output logic [size_y-1:0][0:size_x-1] right_constraint,
  output logic                          map_valid,
  output logic [YW:0]                   rows_loaded,
  output writer_state_t                 dbg_state
);

  localparam logic [YW-1:0] LAST_ROW = YW'(size_y - 1);
  localparam logic [XW-1:0] LAST_COL = XW'(size_x - 1);
  localparam logic [YW:0]   ROWS_MAX = (YW+1)'(size_y);

  writer_state_t                 r_state;
  writer_state_t                 w_next;
  logic [size_y-1:0][0:size_x-1] r_map;
  logic [YW-1:0]                 r_row_cnt;
  logic [YW:0]                   r_rows_loaded;
  logic                          r_map_valid;
  logic                          r_edit_err;
  logic                          w_hs;
  logic                          w_edit_ok;
  logic                          w_edit_err;
  logic                          w_edit_legal;

  function automatic logic [0:size_x-1] fix_row(input logic [0:size_x-1] row);
    fix_row = row;
`ifdef MAZE_RIGHT_BORDER_EN
    fix_row[size_x-1] = 1'b1;
`endif
  endfunction

  // Handshake: a row moves on a clock edge where wr_valid && wr_ready and start is low.
  // wr_ready decodes from state alone, so the source may hold wr_valid before the writer is ready.
  assign wr_ready = (r_state == LOAD);

  always_comb begin
    w_edit_legal = ({1'b0, edit_y} < ROWS_MAX) && ({1'b0, edit_x} < (XW+1)'(size_x));
`ifdef MAZE_RIGHT_BORDER_EN
    if (edit_x == LAST_COL && !edit_val) w_edit_legal = 1'b0;
`endif
  end

  always_comb begin
    w_next     = r_state;
    w_hs       = 1'b0;
    w_edit_ok  = 1'b0;
    w_edit_err = 1'b0;
    case (r_state)
      IDLE:  w_next = IDLE;
      CLEAR: w_next = LOAD;
      LOAD: begin
        if (wr_valid) begin
          w_hs = 1'b1;
          if (r_row_cnt == LAST_ROW) w_next = DONE;
        end
      end
      DONE:    w_edit_ok = edit_valid && w_edit_legal;
      default: w_next = IDLE;
    endcase
    // start overrides everything, including a handshake or edit in the same cycle
    if (start) begin
      w_next    = CLEAR;
      w_hs      = 1'b0;
      w_edit_ok = 1'b0;
    end
    w_edit_err = edit_valid && !start && !w_edit_ok;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_map         <= '0;
      r_row_cnt     <= '0;
      r_rows_loaded <= '0;
      r_map_valid   <= 1'b0;
      r_edit_err    <= 1'b0;
    end else begin
      r_edit_err <= w_edit_err;
      if (start) begin
        r_map_valid <= 1'b0;
      end else if (r_state == CLEAR) begin
        for (int y = 0; y < size_y; y++) r_map[y] <= fix_row('0);
        r_row_cnt     <= '0;
        r_rows_loaded <= '0;
        r_map_valid   <= 1'b0;
      end else if (w_hs) begin
        for (int y = 0; y < size_y; y++) begin
          if (r_row_cnt == YW'(y)) r_map[y] <= fix_row(wr_row);
        end
        if (r_row_cnt != LAST_ROW) r_row_cnt <= r_row_cnt + 1'b1;
        else                       r_map_valid <= 1'b1;
        if (r_rows_loaded < ROWS_MAX) r_rows_loaded <= r_rows_loaded + 1'b1;
      end else if (w_edit_ok) begin
        r_map[edit_y][edit_x] <= edit_val;
      end
    end
  end

  assign right_constraint = r_map;
  assign map_valid        = r_map_valid;
  assign rows_loaded      = r_rows_loaded;
  assign edit_err         = r_edit_err;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_maze_right_writer.sv
// Directed bench for maze_right_writer: row loads, edits, aborts and async reset, checked by a scoreboard.
module tb_maze_right_writer;
  import maze_pkg::*;

  localparam int SY = 20;
  localparam int SX = 40;
  localparam int W  = 45;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  wr_valid;
  logic [0:SX-1]         wr_row;
  logic                  wr_ready;
  logic                  edit_valid;
  logic [4:0]            edit_y;
  logic [5:0]            edit_x;
  logic                  edit_val;
  logic                  edit_err;
  logic [SY-1:0][0:SX-1] right_constraint;
  logic                  map_valid;
  logic [5:0]            rows_loaded;
  writer_state_t         dbg_state;

  maze_right_writer dut (
    .Clk              (clk),
    .Reset_n          (rst_n),
    .start            (start),
    .wr_valid         (wr_valid),
    .wr_row           (wr_row),
    .wr_ready         (wr_ready),
    .edit_valid       (edit_valid),
    .edit_y           (edit_y),
    .edit_x           (edit_x),
    .edit_val         (edit_val),
    .edit_err         (edit_err),
    .right_constraint (right_constraint),
    .map_valid        (map_valid),
    .rows_loaded      (rows_loaded),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_cnt = 0;
  logic [W-1:0]          exp_q[$];
  logic                  err_q[$];
  logic [SY-1:0][0:SX-1] exp_map;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_map(input string name);
    n_cmp++;
    if (right_constraint !== exp_map) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, right_constraint, exp_map);
    end
  endtask

  function automatic logic [0:SX-1] fixr(input logic [0:SX-1] r);
    fixr = r;
`ifdef MAZE_RIGHT_BORDER_EN
    fixr[SX-1] = 1'b1;
`endif
  endfunction

  function automatic logic [0:SX-1] pat1(input int y);
    logic [0:SX-1] r;
    r = '0;
    r[y % SX] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:SX-1] pat2(input int y);
    logic [0:SX-1] r;
    r = '0;
    r[(2*y + 1) % SX] = 1'b1;
    r[0] = 1'b1;
    return r;
  endfunction

  task automatic model_clear();
    for (int y = 0; y < SY; y++) exp_map[y] = fixr('0);
  endtask

  // scoreboard monitor: flags captured mid-cycle describe the next edge; checked one half-cycle after it
  logic hs_pend = 1'b0;
  logic ed_pend = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic         ee;
    if (wr_ready) ready_cnt++;
    if (hs_pend) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL row_unexpected: got handshake expected none");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("row_%0d", e[44:40]), 64'(right_constraint[e[44:40]]), 64'(e[39:0]));
      end
    end
    if (ed_pend) begin
      if (err_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL edit_unexpected: got edit expected none");
      end else begin
        ee = err_q.pop_front();
        check("edit_err", 64'(edit_err), 64'(ee));
      end
    end else if (edit_err) begin
      n_cmp++; n_bad++;
      $display("FAIL edit_err_spurious: got 1 expected 0");
    end
    hs_pend = rst_n && wr_valid && wr_ready && !start;
    ed_pend = rst_n && edit_valid;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_row(input logic [0:SX-1] row, input int y);
    int   n;
    logic ok;
    n = 0;
    wr_valid = 1'b1;
    wr_row   = row;
    do begin
      ok = wr_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_row_timeout: row %0d got no wr_ready expected within 50 cycles", y);
    end else begin
      exp_q.push_back({5'(y), 40'(fixr(row))});
      exp_map[y] = fixr(row);
    end
    wr_valid = 1'b0;
  endtask

  task automatic do_edit(input int y, input int x, input logic v, input logic exp_err);
    edit_valid = 1'b1;
    edit_y     = 5'(y);
    edit_x     = 6'(x);
    edit_val   = v;
    err_q.push_back(exp_err);
    tick();
    edit_valid = 1'b0;
    if (!exp_err) exp_map[y][x] = v;
  endtask

  initial begin
    int t0, t1;
    rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_row = '0;
    edit_valid = 1'b0; edit_y = '0; edit_x = '0; edit_val = 1'b0;
    exp_map = '0;
    #12;
    check("rst_wr_ready", 64'(wr_ready), 64'(0));
    check("rst_map_valid", 64'(map_valid), 64'(0));
    check("rst_rows_loaded", 64'(rows_loaded), 64'(0));
    check("rst_edit_err", 64'(edit_err), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check_map("rst_map");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // back-to-back load with wr_valid held high
    ready_cnt = 0;
    pulse_start();
    model_clear();
    for (int y = 0; y < SY; y++) begin
      send_row(pat1(y), y);
      if (y == SY - 2) check("t1_map_valid_early", 64'(map_valid), 64'(0));
    end
    check("t1_map_valid", 64'(map_valid), 64'(1));
    check("t1_rows_loaded", 64'(rows_loaded), 64'(20));
    tick(); tick();
    check("t1_ready_cycles", 64'(ready_cnt), 64'(20));
    check("t1_bit_7_7", 64'(right_constraint[7][7]), 64'(1));
    check("t1_bit_7_8", 64'(right_constraint[7][8]), 64'(0));
    check_map("t1_map");

    // load with wr_valid toggling every other cycle
    pulse_start();
    model_clear();
    t0 = 0; t1 = 0;
    for (int y = 0; y < SY; y++) begin
      send_row(pat1(y), y);
      if (y == 0) t0 = cyc;
      if (y == SY - 1) t1 = cyc;
      tick();
      if (y == 4 || y == 11) check($sformatf("t2_rows_loaded_%0d", y), 64'(rows_loaded), 64'(y + 1));
    end
    check("t2_span", 64'(t1 - t0 + 1), 64'(39));
    check("t2_rows_loaded", 64'(rows_loaded), 64'(20));
    check_map("t2_map");

    // edits in DONE
    do_edit(3, 12, 1'b1, 1'b0);
    check("t3_bit_3_12", 64'(right_constraint[3][12]), 64'(1));
    do_edit(25, 0, 1'b1, 1'b1);
    tick();
    check_map("t3_map_unchanged");
    do_edit(19, 39, 1'b1, 1'b0);
    check("t3_bit_19_39", 64'(right_constraint[19][39]), 64'(1));

    // start from DONE, abort after 10 rows, reload
    pulse_start();
    check("t4_map_valid_drop", 64'(map_valid), 64'(0));
    model_clear();
    for (int y = 0; y < 10; y++) send_row(pat2(y), y);
    wr_valid = 1'b1; wr_row = pat1(10);
    edit_valid = 1'b1; edit_y = 5'd1; edit_x = 6'd1; edit_val = 1'b1;
    err_q.push_back(1'b0);
    pulse_start();
    wr_valid = 1'b0; edit_valid = 1'b0;
    model_clear();
    tick();
    check_map("t4_map_cleared");
    check("t4_rows_loaded_clr", 64'(rows_loaded), 64'(0));
    for (int y = 0; y < SY; y++) begin
      send_row(pat2(y), y);
      if (y == SY - 2) check("t4_map_valid_early", 64'(map_valid), 64'(0));
    end
    check("t4_map_valid", 64'(map_valid), 64'(1));
    check_map("t4_map");

    // asynchronous reset mid-load
    pulse_start();
    model_clear();
    for (int y = 0; y < 5; y++) send_row(pat1(y), y);
    tick();
    #2 rst_n = 1'b0;
    #1;
    exp_map = '0;
    check_map("t5_map_reset");
    check("t5_map_valid", 64'(map_valid), 64'(0));
    check("t5_wr_ready", 64'(wr_ready), 64'(0));
    check("t5_rows_loaded", 64'(rows_loaded), 64'(0));
    check("t5_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    wr_valid = 1'b1; wr_row = pat1(0);
    tick(); tick(); tick();
    check("t5_idle_ready", 64'(wr_ready), 64'(0));
    check("t5_idle_rows", 64'(rows_loaded), 64'(0));
    wr_valid = 1'b0;
    do_edit(0, 0, 1'b1, 1'b1);
    tick();
    check_map("t5_idle_map");

`ifdef MAZE_RIGHT_BORDER_EN
    pulse_start();
    model_clear();
    for (int y = 0; y < SY; y++) send_row('0, y);
    for (int y = 0; y < SY; y++) check($sformatf("t6_border_%0d", y), 64'(right_constraint[y][39]), 64'(1));
    do_edit(0, 39, 1'b0, 1'b1);
    tick();
    check("t6_border_edit", 64'(right_constraint[0][39]), 64'(1));
`endif

    tick(); tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    check("err_q_drained", 64'(err_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/maze_right_writer.md
Name: maze_right_writer

Overview:
- Builds and maintains the per-cell "wall on right" map that the movement deny logic reads to block rightward player motion.
- Loads the maze one row per handshake from a row source (ROM sequencer or host) into a registered map.
- Publishes the map with a valid flag and accepts single-cell edits once the map is loaded.

Parameters:
- size_y, 20, number of maze rows
- size_x, 40, number of maze columns
- YW, $clog2(size_y), row index width (derived; do not override)
- XW, $clog2(size_x), column index width (derived; do not override)

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears the map and begins a full reload
- wr_valid  input  1  row source has a row on wr_row
- wr_row  input  [0:size_x-1]  right-wall bits for the current row; bit x = cell x
- wr_ready  output  1  writer accepts the row this cycle
- edit_valid  input  1  single-cell edit request
- edit_y  input  YW  edit row
- edit_x  input  XW  edit column
- edit_val  input  1  new wall bit
- edit_err  output  1  one-cycle pulse: edit rejected
- right_constraint  output  [0:size_x-1] x [size_y-1:0]  registered wall map, same shape the deny logic consumes
- map_valid  output  1  map is completely loaded
- rows_loaded  output  YW+1  number of rows accepted in the current load

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE; right_constraint all 0; map_valid=0; wr_ready=0; edit_err=0; rows_loaded=0.
- States: IDLE, CLEAR, LOAD, DONE.
- IDLE:
  - wr_ready=0; wr_valid and edit_valid are ignored.
  - start -> CLEAR.
- CLEAR (exactly 1 cycle):
  - All right_constraint bits := 0; row counter := 0; rows_loaded := 0; map_valid := 0.
  - Next state LOAD.
- LOAD:
  - wr_ready=1 combinationally.
  - Row transfer when wr_valid && wr_ready: right_constraint[row counter] := wr_row; counter and rows_loaded increment.
  - The row is visible on right_constraint the following cycle.
  - On the transfer of row size_y-1 -> DONE; map_valid=1 from the next cycle.
  - wr_valid low: state holds, nothing is written.
- DONE:
  - wr_ready=0; map_valid=1.
  - Edit accepted when edit_valid && edit_y<size_y && edit_x<size_x: right_constraint[edit_y][edit_x] := edit_val, visible the next cycle.
  - Out-of-range edit: map unchanged; edit_err=1 for one cycle.
- Edits in IDLE, CLEAR or LOAD: rejected with an edit_err pulse.
- start has priority over everything in every state:
  - In LOAD it aborts the current load; a row handshake in that same cycle is discarded.
  - In DONE it drops map_valid at the next edge and reloads.
- Simultaneous start and edit: the edit is dropped, and edit_err is not pulsed.
- rows_loaded saturates at size_y; the row counter never wraps inside a load.
- Reset asserted mid-load: the map returns to all 0 immediately; no partial rows survive.
- All outputs are registered except wr_ready, which decodes from state only and never from wr_valid.

Optional Feature:
- Macro: MAZE_RIGHT_BORDER_EN.
- Defined:
  - Column size_x-1 of every row is forced to 1 on every row write, every edit and in CLEAR, so the east border is always a wall.
  - An edit targeting x=size_x-1 with edit_val=0 is rejected with edit_err.
- Undefined: column size_x-1 stores exactly what is written.

Decomposition:
- Shared package maze_pkg holds:
  - constants MAZE_SIZE_Y=20 and MAZE_SIZE_X=40;
  - typedef maze_row_t = logic [0:MAZE_SIZE_X-1];
  - enum writer_state_t {IDLE, CLEAR, LOAD, DONE}.
- The same package serves the deny checkers and any future top/bottom/left map writers.
- No sub-module: the map register array and the FSM live in one module.
- The per-row write-enable decode stays inline.

Test Plan:
- Reset_n low, then start; stream 20 rows with row y = pattern (bit y%40 set), wr_valid held high -> wr_ready high for exactly 20 cycles; map_valid=1 on the cycle after the 20th transfer; rows_loaded=20; right_constraint[7][7]=1, right_constraint[7][8]=0.
- Same load with wr_valid toggling every other cycle -> 20 transfers over 39 cycles; no row is skipped or duplicated; rows_loaded increments only on handshakes.
- In DONE: edit (y=3, x=12, val=1), then edit (y=25, x=0) -> bit [3][12]=1 on the next cycle; second edit gives a one-cycle edit_err and the map is unchanged.
- start issued after 10 rows -> map all 0 two cycles later; the reload accepts rows from index 0; map_valid stays 0 until the 20th new row.
- Reset_n pulsed low mid-load at row 5 -> all outputs at reset values asynchronously, before the next Clk edge; writer idle until start.
- MAZE_RIGHT_BORDER_EN defined: load all-zero rows -> column 39 reads 1 in every row; edit (y=0, x=39, val=0) -> edit_err and bit stays 1.
